// File: rtl/ysyx_22041211_csr_unit_if.sv
// CSR unit bus: Zicsr request/response, trap/mret requests and the IFU redirect handshake.
// master drives requests (EXU/controller side), slave is the CSR unit.
interface ysyx_22041211_csr_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  csr_valid_i;
  logic [1:0]            csr_op_i;
  logic [11:0]           csr_addr_i;
  logic [DATA_WIDTH-1:0] csr_wdata_i;
  logic [DATA_WIDTH-1:0] csr_rdata_o;
  logic                  illegal_o;
  logic                  trap_req_i;
  logic [DATA_WIDTH-1:0] trap_cause_i;
  logic [DATA_WIDTH-1:0] trap_pc_i;
  logic                  mret_req_i;
  logic                  redirect_valid_o;
  logic                  redirect_ready_i;
  logic [DATA_WIDTH-1:0] redirect_pc_o;
  logic                  busy_o;

  modport master (
    output csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output trap_req_i, trap_cause_i, trap_pc_i, mret_req_i, redirect_ready_i,
    input  csr_rdata_o, illegal_o, redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  trap_req_i, trap_cause_i, trap_pc_i, mret_req_i, redirect_ready_i,
    output csr_rdata_o, illegal_o, redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/ysyx_22041211_csr_unit.sv
// Machine-mode CSR file with trap/mret sequencer and PC redirect handshake.
// Optional cycle counter (mcycle/mcycleh) enabled by defining CSR_MCYCLE_EN.
module ysyx_22041211_csr_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = '0,
  parameter logic [DATA_WIDTH-1:0] MARCHID     = '0
) (
  input logic clock,
  input logic reset,
  ysyx_22041211_csr_unit_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] ALIGN = ~DW'(3);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
`ifdef CSR_MCYCLE_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
`endif

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t        state;
  logic          mie, mpie;
  logic [DW-1:0] mtvec, mscratch, mepc, mcause;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;

`ifdef CSR_MCYCLE_EN
  logic [63:0]   mcycle;
  logic [DW-1:0] mcycle_hi;
  assign mcycle_hi = DW'(mcycle[63:32]);
`endif

  // Only MIE/MPIE are stored; MPP reads back as machine mode.
  logic [DW-1:0] mstatus_val;
  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mpie;
    mstatus_val[3]     = mie;
  end

  logic          known, ro, eff_write, active, illegal, do_write;
  logic [DW-1:0] old_val, new_val;

  always_comb begin
    known   = 1'b1;
    ro      = 1'b0;
    old_val = '0;
    case (bus.csr_addr_i)
      A_MSTATUS:   old_val = mstatus_val;
      A_MTVEC:     old_val = mtvec;
      A_MSCRATCH:  old_val = mscratch;
      A_MEPC:      old_val = mepc;
      A_MCAUSE:    old_val = mcause;
      A_MVENDORID: ro = 1'b1;
      A_MARCHID:   begin ro = 1'b1; old_val = MARCHID; end
`ifdef CSR_MCYCLE_EN
      A_MCYCLE:    old_val = mcycle[DW-1:0];
      A_MCYCLEH:   if (DW == 32) old_val = mcycle_hi; else known = 1'b0;
`endif
      default:     known = 1'b0;
    endcase
  end

  // A CSR op only counts when idle and no trap/mret wins the cycle.
  assign active    = (state == IDLE) && bus.csr_valid_i && (bus.csr_op_i != 2'b00)
                     && !bus.trap_req_i && !bus.mret_req_i;
  assign eff_write = (bus.csr_op_i == OP_RW) || (bus.csr_wdata_i != '0);
  assign illegal   = active && (!known || (ro && eff_write));
  assign do_write  = active && known && !ro && eff_write;

  always_comb begin
    new_val = '0;
    case (bus.csr_op_i)
      OP_RW:   new_val = bus.csr_wdata_i;
      OP_RS:   new_val = old_val | bus.csr_wdata_i;
      OP_RC:   new_val = old_val & ~bus.csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  assign bus.csr_rdata_o      = (known && !illegal) ? old_val : '0;
  assign bus.illegal_o        = illegal;
  assign bus.redirect_valid_o = redirect_valid;
  assign bus.redirect_pc_o    = redirect_pc;
  assign bus.busy_o           = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mie            <= 1'b0;
      mpie           <= 1'b0;
      mtvec          <= MTVEC_RESET & ALIGN;
      mscratch       <= '0;
      mepc           <= '0;
      mcause         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.trap_req_i) begin
            mepc           <= bus.trap_pc_i & ALIGN;
            mcause         <= bus.trap_cause_i;
            mpie           <= mie;
            mie            <= 1'b0;
            redirect_pc    <= mtvec;
            redirect_valid <= 1'b1;
            state          <= REDIRECT;
          end else if (bus.mret_req_i) begin
            mie            <= mpie;
            mpie           <= 1'b1;
            redirect_pc    <= mepc;
            redirect_valid <= 1'b1;
            state          <= REDIRECT;
          end else if (do_write) begin
            case (bus.csr_addr_i)
              A_MSTATUS:  begin mie <= new_val[3]; mpie <= new_val[7]; end
              A_MTVEC:    mtvec    <= new_val & ALIGN;
              A_MSCRATCH: mscratch <= new_val;
              A_MEPC:     mepc     <= new_val & ALIGN;
              A_MCAUSE:   mcause   <= new_val;
              default:    ;
            endcase
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready_i) begin
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CSR_MCYCLE_EN
  // A written half takes the write value; the counter skips that cycle's increment.
  always_ff @(posedge clock) begin
    if (reset)
      mcycle <= '0;
    else if (do_write && bus.csr_addr_i == A_MCYCLE)
      mcycle[DW-1:0] <= new_val;
    else if (do_write && bus.csr_addr_i == A_MCYCLEH)
      mcycle[63:32] <= new_val[31:0];
    else
      mcycle <= mcycle + 64'd1;
  end
`endif
endmodule

// File: tb/tb_ysyx_22041211_csr_unit.sv
// Bench for ysyx_22041211_csr_unit: directed spot checks plus random traffic against a CSR map model.
module tb_ysyx_22041211_csr_unit;
  localparam logic [31:0] MTVEC_R = 32'h8000_0000;
  localparam logic [31:0] MARCH   = 32'h0000_1234;
`ifdef CSR_MCYCLE_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_22041211_csr_unit_if #(.DATA_WIDTH(32)) bus ();

  ysyx_22041211_csr_unit #(.DATA_WIDTH(32), .MTVEC_RESET(MTVEC_R), .MARCHID(MARCH)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: CSR map keyed by address ----------------
  logic [31:0] m_csr [logic [11:0]];
  logic [63:0] m_cyc;
  bit          m_busy, m_init;
  logic [31:0] m_rpc;

  function automatic bit m_known(input logic [11:0] a);
    return m_csr.exists(a) || (CYC_EN && (a == 12'hB00 || a == 12'hB80));
  endfunction
  // Architectural convention: addr[11:10]==11 marks read-only CSRs.
  function automatic bit m_ro(input logic [11:0] a);
    return a[11:10] == 2'b11;
  endfunction
  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (CYC_EN && a == 12'hB00) return m_cyc[31:0];
    if (CYC_EN && a == 12'hB80) return m_cyc[63:32];
    if (m_csr.exists(a)) return m_csr[a];
    return 32'h0;
  endfunction
  function automatic logic [31:0] m_warl(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300:          return (v & 32'h88) | 32'h1800;
      12'h305, 12'h341: return v & ~32'h3;
      default:          return v;
    endcase
  endfunction
  function automatic bit m_active();
    return !m_busy && bus.csr_valid_i && bus.csr_op_i != 2'b00 && !bus.trap_req_i && !bus.mret_req_i;
  endfunction
  function automatic bit m_eff();
    return bus.csr_op_i == 2'b01 || bus.csr_wdata_i != 32'h0;
  endfunction

  always @(posedge clock) begin
    bit          wr_cyc;
    logic [31:0] old, nv, st;
    wr_cyc = 1'b0;
    if (reset) begin
      m_csr.delete();
      m_csr[12'h300] = 32'h1800;
      m_csr[12'h305] = MTVEC_R & ~32'h3;
      m_csr[12'h340] = 0; m_csr[12'h341] = 0; m_csr[12'h342] = 0;
      m_csr[12'hF11] = 0; m_csr[12'hF12] = MARCH;
      m_cyc = 0; m_busy = 0; m_rpc = 0; m_init = 1;
    end else if (m_init) begin
      st = m_csr[12'h300];
      if (!m_busy) begin
        if (bus.trap_req_i) begin
          m_csr[12'h341] = bus.trap_pc_i & ~32'h3;
          m_csr[12'h342] = bus.trap_cause_i;
          m_csr[12'h300] = 32'h1800 | (st[3] ? 32'h80 : 32'h0);
          m_rpc = m_csr[12'h305]; m_busy = 1;
        end else if (bus.mret_req_i) begin
          m_csr[12'h300] = 32'h1880 | (st[7] ? 32'h8 : 32'h0);
          m_rpc = m_csr[12'h341]; m_busy = 1;
        end else if (m_active() && m_known(bus.csr_addr_i) && !m_ro(bus.csr_addr_i) && m_eff()) begin
          old = m_read(bus.csr_addr_i);
          case (bus.csr_op_i)
            2'b01:   nv = bus.csr_wdata_i;
            2'b10:   nv = old | bus.csr_wdata_i;
            default: nv = old & ~bus.csr_wdata_i;
          endcase
          if (bus.csr_addr_i == 12'hB00)      begin m_cyc[31:0]  = nv; wr_cyc = 1; end
          else if (bus.csr_addr_i == 12'hB80) begin m_cyc[63:32] = nv; wr_cyc = 1; end
          else m_csr[bus.csr_addr_i] = m_warl(bus.csr_addr_i, nv);
        end
      end else if (bus.redirect_ready_i) m_busy = 0;
      if (!wr_cyc) m_cyc = m_cyc + 1;
    end
  end

  // Single compare process: every output, every cycle once the model is initialised.
  always @(negedge clock) begin
    bit          ill;
    logic [31:0] rd;
    if (m_init) begin
      ill = m_active() && (!m_known(bus.csr_addr_i) || (m_ro(bus.csr_addr_i) && m_eff()));
      rd  = (!m_known(bus.csr_addr_i) || ill) ? 32'h0 : m_read(bus.csr_addr_i);
      chk("cmp_rdata",   bus.csr_rdata_o, rd);
      chk("cmp_illegal", {31'h0, bus.illegal_o}, {31'h0, ill});
      chk("cmp_busy",    {31'h0, bus.busy_o}, {31'h0, m_busy});
      chk("cmp_rvalid",  {31'h0, bus.redirect_valid_o}, {31'h0, m_busy});
      chk("cmp_rpc",     bus.redirect_pc_o, m_rpc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    bus.csr_valid_i = 0; bus.csr_op_i = 0; bus.csr_addr_i = 0; bus.csr_wdata_i = 0;
    bus.trap_req_i = 0; bus.trap_cause_i = 0; bus.trap_pc_i = 0; bus.mret_req_i = 0;
    bus.redirect_ready_i = 1;
  endtask
  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
    bus.csr_valid_i = 1; bus.csr_op_i = op; bus.csr_addr_i = a; bus.csr_wdata_i = w;
  endtask
  task automatic nxt();
    @(posedge clock); #1; clr();
  endtask
  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr(2'b10, a, 32'h0); @(negedge clock); chk(name, bus.csr_rdata_o, exp); nxt();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pool [10];
    pool = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'hB00, 12'hB80, 12'h7C0};
    clr();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;

    csr(2'b10, 12'h300, 0); @(negedge clock);
    chk("rst_mstatus", bus.csr_rdata_o, 32'h1800);
    chk("rst_rvalid", {31'h0, bus.redirect_valid_o}, 32'h0);
    chk("rst_rpc", bus.redirect_pc_o, 32'h0);
    chk("rst_busy", {31'h0, bus.busy_o}, 32'h0);
    nxt();
    rd_chk("rst_mtvec", 12'h305, 32'h8000_0000);

    csr(2'b01, 12'h305, 32'h8000_0103); nxt();
    rd_chk("mtvec_warl", 12'h305, 32'h8000_0100);
    csr(2'b10, 12'h340, 32'h0F); nxt();
    csr(2'b11, 12'h340, 32'h03); @(negedge clock); chk("rc_old", bus.csr_rdata_o, 32'h0F); nxt();
    rd_chk("rs_rc_result", 12'h340, 32'h0C);
    csr(2'b10, 12'h300, 0); @(negedge clock);
    chk("rs0_legal", {31'h0, bus.illegal_o}, 32'h0); nxt();
    csr(2'b10, 12'h300, 32'h8); nxt();

    // trap with a 3-cycle stalled redirect; CSR writes during the stall are ignored
    bus.trap_req_i = 1; bus.trap_cause_i = 11; bus.trap_pc_i = 32'h8000_0010; nxt();
    repeat (3) begin
      bus.redirect_ready_i = 0; csr(2'b01, 12'h340, 32'hDEAD_BEEF); @(negedge clock);
      chk("stall_valid", {31'h0, bus.redirect_valid_o}, 32'h1);
      chk("stall_pc", bus.redirect_pc_o, 32'h8000_0100);
      chk("stall_busy", {31'h0, bus.busy_o}, 32'h1);
      chk("stall_illegal", {31'h0, bus.illegal_o}, 32'h0);
      nxt();
    end
    @(negedge clock); chk("accept_valid", {31'h0, bus.redirect_valid_o}, 32'h1); nxt();
    csr(2'b10, 12'h341, 0); @(negedge clock);
    chk("idle_after_accept", {31'h0, bus.busy_o}, 32'h0);
    chk("trap_mepc", bus.csr_rdata_o, 32'h8000_0010); nxt();
    rd_chk("trap_mcause", 12'h342, 32'd11);
    rd_chk("trap_mstatus", 12'h300, 32'h1880);
    rd_chk("stall_no_write", 12'h340, 32'h0C);

    csr(2'b01, 12'h341, 32'h8000_0014); nxt();
    bus.mret_req_i = 1; nxt();
    @(negedge clock); chk("mret_pc", bus.redirect_pc_o, 32'h8000_0014); nxt();
    rd_chk("mret_mstatus", 12'h300, 32'h1888);

    csr(2'b01, 12'hF11, 32'h1); @(negedge clock);
    chk("ro_write_ill", {31'h0, bus.illegal_o}, 32'h1); chk("ro_write_rd", bus.csr_rdata_o, 0); nxt();
    csr(2'b10, 12'h7C0, 0); @(negedge clock);
    chk("bad_addr_ill", {31'h0, bus.illegal_o}, 32'h1); chk("bad_addr_rd", bus.csr_rdata_o, 0); nxt();
    rd_chk("marchid", 12'hF12, MARCH);

    csr(2'b01, 12'h340, 32'h55); bus.mret_req_i = 1;
    bus.trap_req_i = 1; bus.trap_cause_i = 2; bus.trap_pc_i = 32'h8000_0023; nxt();
    @(negedge clock); chk("prio_pc", bus.redirect_pc_o, 32'h8000_0100); nxt();
    rd_chk("prio_mcause", 12'h342, 32'd2);
    rd_chk("prio_mepc", 12'h341, 32'h8000_0020);
    rd_chk("prio_no_csr", 12'h340, 32'h0C);

`ifdef CSR_MCYCLE_EN
    csr(2'b01, 12'hB80, 32'h5); nxt();
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF); nxt();
    rd_chk("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    rd_chk("mcycle_wrap", 12'hB00, 32'h0);
    rd_chk("mcycleh_carry", 12'hB80, 32'h6);
`else
    csr(2'b10, 12'hB00, 0); @(negedge clock);
    chk("no_mcycle_ill", {31'h0, bus.illegal_o}, 32'h1); nxt();
`endif

    // random traffic, including stalls, collisions and occasional resets
    for (int i = 0; i < 3000; i++) begin
      bus.csr_valid_i      = ($urandom % 4) != 0;
      bus.csr_op_i         = 2'($urandom);
      bus.csr_addr_i       = ($urandom % 8 == 0) ? 12'($urandom) : pool[$urandom % 10];
      bus.csr_wdata_i      = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      bus.trap_req_i       = ($urandom % 10) == 0;
      bus.trap_cause_i     = $urandom;
      bus.trap_pc_i        = $urandom;
      bus.mret_req_i       = ($urandom % 10) == 0;
      bus.redirect_ready_i = 1'($urandom);
      reset                = ($urandom % 100) == 0;
      @(posedge clock); #1;
    end
    reset = 0; clr();
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
